// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly,
// optional CBC chaining selected by MODE.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    // Row-major FIPS-197 table; entry 0 sits in the top byte, so index with ~a_i.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y_o = SBOX[~a_i];
endmodule

module aes_enc_iter #(
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    typedef logic [0:15][7:0] blk_t;
    typedef enum logic [1:0] {IDLE, ROUND, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        key_loaded_q, key_loaded_d;
    logic        out_valid_q, out_valid_d;
    blk_t        key_q, key_d;
    blk_t        chain_q, chain_d;
    blk_t        rk_q, rk_d;
    blk_t        st_q, st_d;
    blk_t        out_q, out_d;

    blk_t        sb_o, sr, mc, nk, rnd;
    logic [0:3][7:0] ks_i, ks_o;
    logic        rdy;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_sb
        aes_sbox u_sb (.a_i(st_q[g]), .y_o(sb_o[g]));
    end
    for (genvar g = 0; g < 4; g++) begin : g_ks
        aes_sbox u_ks (.a_i(ks_i[g]), .y_o(ks_o[g]));
    end

    // Byte 4c+r holds row r of column c.
    always_comb begin
        sr   = '0;
        mc   = '0;
        nk   = '0;
        ks_i = {rk_q[13], rk_q[14], rk_q[15], rk_q[12]};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb_o[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
        end
        for (int b = 0; b < 4; b++) begin
            nk[b] = rk_q[b] ^ ks_o[b] ^ ((b == 0) ? rcon_q : 8'h00);
        end
        for (int w = 1; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                nk[4*w+b] = rk_q[4*w+b] ^ nk[4*(w-1)+b];
            end
        end
        rnd = ((cnt_q == 4'd10) ? sr : mc) ^ nk;
    end

    assign rdy = (state_q == IDLE) && key_loaded_q && !key_valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rcon_d       = rcon_q;
        key_loaded_d = key_loaded_q;
        out_valid_d  = out_valid_q;
        key_d        = key_q;
        chain_d      = chain_q;
        rk_d         = rk_q;
        st_d         = st_q;
        out_d        = out_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d        = key;
                    chain_d      = iv;
                    key_loaded_d = 1'b1;
                end else if (in_valid && rdy) begin
                    st_d    = in_data ^ key_q ^ ((MODE == 1) ? chain_q : '0);
                    rk_d    = key_q;
                    rcon_d  = 8'h01;
                    cnt_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d   = rnd;
                rk_d   = nk;
                rcon_d = xt(rcon_q);
                if (cnt_q == 4'd10) begin
                    out_d       = rnd;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (MODE == 1) chain_d = out_q;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rcon_q       <= 8'h00;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            key_q        <= '0;
            chain_q      <= '0;
            rk_q         <= '0;
            st_q         <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcon_q       <= rcon_d;
            key_loaded_q <= key_loaded_d;
            out_valid_q  <= out_valid_d;
            key_q        <= key_d;
            chain_q      <= chain_d;
            rk_q         <= rk_d;
            st_q         <= st_d;
            out_q        <= out_d;
        end
    end

    assign in_ready  = rdy;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: ECB and CBC instances share stimulus and are checked every
// cycle against a transaction-level AES model; known-answer vectors pin the model.

module tb_aes_enc_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key = '0, iv = '0, in_data = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [127:0] out_data0, out_data1;

    int checks = 0;
    int errs   = 0;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] P2  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] C2  = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P3A = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C3A = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P3B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C3B = 128'h5086cb9b507219ee95db113a917678b2;

    aes_enc_iter #(.MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0));
    aes_enc_iter #(.MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1));

    always #5 clk = ~clk;

    // Reference AES built from field arithmetic, not from a stored table.
    logic [7:0] sbx [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbx[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbx[tmp[31:24]] ^ rc, sbx[tmp[23:16]], sbx[tmp[15:8]], sbx[tmp[7:0]]};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbx[s[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
                    s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Transaction model: a block takes 10 edges, then waits for the consumer.
    logic         m_loaded = 1'b0, m_ov = 1'b0;
    int           m_left = 0;
    logic [127:0] m_key = '0, m_chain = '0, m_out0 = '0, m_out1 = '0, p0 = '0, p1 = '0;
    wire          m_idle = !m_ov && (m_left == 0);
    wire          m_rdy  = m_idle && m_loaded && !key_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loaded <= 1'b0; m_ov <= 1'b0; m_left <= 0;
            m_key <= '0; m_chain <= '0; m_out0 <= '0; m_out1 <= '0;
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov    <= 1'b0;
                m_chain <= m_out1;
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ov <= 1'b1; m_out0 <= p0; m_out1 <= p1;
            end
        end else if (key_valid) begin
            m_key <= key; m_chain <= iv; m_loaded <= 1'b1;
        end else if (in_valid && m_loaded) begin
            p0 <= aes_ref(m_key, in_data);
            p1 <= aes_ref(m_key, in_data ^ m_chain);
            m_left <= 10;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready0",  {127'b0, in_ready0},  {127'b0, m_rdy});
        chk("in_ready1",  {127'b0, in_ready1},  {127'b0, m_rdy});
        chk("out_valid0", {127'b0, out_valid0}, {127'b0, m_ov});
        chk("out_valid1", {127'b0, out_valid1}, {127'b0, m_ov});
        chk("busy0",      {127'b0, busy0},      {127'b0, !m_idle});
        chk("busy1",      {127'b0, busy1},      {127'b0, !m_idle});
        chk("out_data0",  out_data0, m_out0);
        chk("out_data1",  out_data1, m_out1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input logic [127:0] v);
        key = k; iv = v; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic start_block(input logic [127:0] d, output int lat);
        int n = 0;
        in_data = d; in_valid = 1'b1;
        #1;
        while (!in_ready0 && n < 50) begin tick(); n++; end
        if (n == 50) chk("accept_wait", {127'b0, in_ready0}, 128'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 40) begin tick(); lat++; end
    endtask

    task automatic finish_block();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        init_sbox();
        chk("ref_kat1",  aes_ref(K1, P1), C1);
        chk("ref_kat2",  aes_ref(K2, P2), C2);
        chk("ref_cbc1",  aes_ref(K3, P3A ^ K1), C3A);
        chk("ref_cbc2",  aes_ref(K3, P3B ^ C3A), C3B);

        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_out_data", out_data0, '0);
        chk("rst_in_ready", {127'b0, in_ready0}, '0);
        chk("rst_busy",     {127'b0, busy0}, '0);
        rst_n = 1'b1;
        tick();
        chk("no_key_ready", {127'b0, in_ready0}, '0);

        load_key(K1, K1);
        start_block(P1, lat);
        chk("lat_kat1", 128'(lat), 128'd10);
        chk("kat1", out_data0, C1);
        finish_block();

        load_key(K2, '0);
        start_block(P2, lat);
        chk("kat2a", out_data0, C2);
        finish_block();
        start_block(P2, lat);
        chk("kat2b", out_data0, C2);
        finish_block();

        load_key(K3, K1);
        start_block(P3A, lat);
        chk("cbc1", out_data1, C3A);
        finish_block();
        start_block(P3B, lat);
        chk("cbc2", out_data1, C3B);
        finish_block();

        // Long back-pressure with ignored traffic on both input strobes.
        load_key(K1, K1);
        start_block(P1, lat);
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'($urandom % 2);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            key_valid = (i == 5 || i == 12);
            key       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; key_valid = 1'b0;
        #1;
        chk("hold_data",  out_data0, C1);
        chk("hold_ready", {127'b0, in_ready0}, '0);
        finish_block();
        start_block(P1, lat);
        chk("hold_after", out_data0, C1);
        finish_block();

        // Simultaneous key load and block offer right after reset.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        key = K1; iv = K1; key_valid = 1'b1; in_valid = 1'b1; in_data = P1;
        #1;
        chk("kv_wins", {127'b0, in_ready0}, '0);
        tick();
        key_valid = 1'b0;
        #1;
        chk("ready_after_key", {127'b0, in_ready0}, 128'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 40) begin tick(); lat++; end
        chk("lat_kv", 128'(lat), 128'd10);
        chk("kv_data", out_data0, C1);
        finish_block();

        // Reset mid-ROUND aborts the block.
        load_key(K1, K1);
        in_data = P1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {127'b0, out_valid0}, '0);
        chk("abort_busy",  {127'b0, busy0}, '0);
        chk("abort_data",  out_data0, '0);
        chk("abort_data1", out_data1, '0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (5) tick();
        chk("abort_noready", {127'b0, in_ready0}, '0);
        in_valid = 1'b0;
        load_key(K1, K1);
        start_block(P1, lat);
        chk("abort_redo", out_data0, C1);
        finish_block();

        // Random traffic, back-pressure and occasional key reloads.
        for (int i = 0; i < 800; i++) begin
            key_valid = ($urandom % 40 == 0);
            key       = {$urandom, $urandom, $urandom, $urandom};
            iv        = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 1'($urandom % 2);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom % 3 != 0);
            tick();
        end
        key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (15) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/aes_enc_iter.md
AES_ENC_ITER -- requirements
Module: aes_enc_iter

Interface
REQ-001 SHALL have parameter MODE, default 0, chaining mode: 0 = ECB, 1 = CBC.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port key_valid  input  1  load-key strobe.
REQ-005 SHALL have port key  input  128  AES-128 cipher key, byte 0 in bits [127:120].
REQ-006 SHALL have port iv  input  128  CBC initial vector, sampled with key; ignored when MODE=0.
REQ-007 SHALL have port in_valid  input  1  plaintext block offered.
REQ-008 SHALL have port in_ready  output  1  block accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port in_data  input  128  plaintext block, byte 0 in bits [127:120].
REQ-010 SHALL have port out_valid  output  1  ciphertext available.
REQ-011 SHALL have port out_ready  input  1  ciphertext taken when out_valid and out_ready are both 1.
REQ-012 SHALL have port out_data  output  128  ciphertext block.
REQ-013 SHALL have port busy  output  1  high in ROUND or HOLD.

Function
REQ-014 SHALL implement FIPS-197 AES-128 encryption: one round per clock, with on-the-fly key expansion (round key and rcon advanced each ROUND cycle, no stored key schedule).
REQ-015 SHALL use FSM states IDLE, ROUND, HOLD, with a 4-bit round counter.
REQ-016 IDLE with key_valid=1: key register <= key, chain register <= iv, key_loaded <= 1; the state stays IDLE.
REQ-017 key_valid outside IDLE SHALL be ignored; the key in use is not altered.
REQ-018 in_ready SHALL equal (state==IDLE) AND key_loaded AND NOT key_valid, so a key load wins over a simultaneous block.
REQ-019 On input handshake: state <= in_data XOR key XOR (chain if MODE=1, else 0); round key <= key; counter <= 1; go to ROUND.
REQ-020 In ROUND, counter 1..9 SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey; counter 10 SHALL omit MixColumns, load the result into out_data, set out_valid and go to HOLD.
REQ-021 Latency: handshake at edge N SHALL give out_valid=1 after edge N+10.
REQ-022 In HOLD, out_data SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 On output handshake: out_valid <= 0; chain <= out_data when MODE=1; go to IDLE. The minimum block period is 12 cycles.
REQ-024 The chain register SHALL persist across blocks until the next key load, which re-seeds it from iv.
REQ-025 in_ready SHALL be 0 in ROUND and HOLD; in_valid in those states SHALL have no effect.
REQ-026 out_data SHALL retain the last ciphertext after the handshake, until it is overwritten at the next counter-10 cycle.
REQ-027 The S-box SHALL be the FIPS-197 table (lookup or composite-field logic); 16 state lookups plus 4 key-schedule lookups per cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, counter 0, key_loaded 0, in_ready 0, out_valid 0, busy 0, and out_data, key, round key and chain all zero.
REQ-029 Reset asserted mid-ROUND or mid-HOLD SHALL abort the block with no output; after release, a key load is required before in_ready rises.
REQ-030 Release SHALL be synchronised by the integrator; the block samples nothing on the release edge beyond normal operation.

Verification
REQ-031 MODE=0: key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
REQ-032 MODE=0: key 5468617473206D79204B756E67204675, in_data 54776F204F6E65204E696E652054776F -> out_data 29C3505F571420F6402299B31A02D73A; then the same block again -> identical output.
REQ-033 MODE=1: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f, in_data 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d; next block ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
REQ-034 out_ready held 0 for 20 cycles in HOLD -> out_data stable, in_ready 0, and in_valid pulses plus key_valid are ignored; after release, REQ-031 output is unchanged.
REQ-035 key_valid and in_valid asserted together in IDLE after reset -> in_ready 0 that cycle, key loaded, block accepted the next cycle with the new key.
REQ-036 rst_n pulsed low at counter 5 -> outputs zero at once, no out_valid, in_ready stays 0 until a key load, after which REQ-031 reproduces.
